// File: rtl/rfile_mp_pkg.sv
// Shared types and lane-mask helpers for the multi-port register file.
package rfile_mp_pkg;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} wsize_e;

    localparam int unsigned MAX_LANE = 64;

    function automatic int unsigned calc_nlane(input int unsigned xlen);
        return xlen / 8;
    endfunction

    function automatic int unsigned calc_pw(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // Sizes wider than the register collapse to a full-register write.
    function automatic int unsigned lane_bytes(input wsize_e size, input int unsigned nlane);
        int unsigned b;
        b = 32'd1 << size;
        return (b > nlane) ? nlane : b;
    endfunction

    function automatic int unsigned lane_first(input wsize_e size, input int unsigned pos,
                                               input int unsigned nlane);
        return (pos * lane_bytes(size, nlane)) % nlane;
    endfunction

    function automatic logic [MAX_LANE-1:0] lane_mask(input wsize_e size, input int unsigned pos,
                                                      input int unsigned nlane);
        int unsigned b;
        int unsigned l0;
        logic [MAX_LANE-1:0] m;
        b  = lane_bytes(size, nlane);
        l0 = lane_first(size, pos, nlane);
        m  = '0;
        for (int unsigned k = 0; k < MAX_LANE; k++) begin
            if (k >= l0 && k < l0 + b && k < nlane) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rfile_mp_merge.sv
// Per-register write merge: higher port index wins each byte lane; flags lane overlap.
module rfile_mp_merge #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NWR   = 3,
    parameter int unsigned NLANE = XLEN / 8
) (
    input  logic [XLEN-1:0]                cur,
    input  logic [NWR-1:0]                 hit,
    input  logic [NWR-1:0][NLANE-1:0]      mask,
    input  logic [NWR-1:0][XLEN-1:0]       data,
    output logic [XLEN-1:0]                next,
    output logic [NLANE-1:0]               lane_we,
    output logic                           overlap
);

    always_comb begin
        next    = cur;
        lane_we = '0;
        overlap = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (hit[j]) begin
                // Overlap is judged against lanes already claimed by lower ports.
                overlap = overlap | (|(lane_we & mask[j]));
                lane_we = lane_we | mask[j];
                for (int l = 0; l < NLANE; l++) begin
                    if (mask[j][l]) next[l*8 +: 8] = data[j][l*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/rfile_mp.sv
// Multi-port register file with byte-lane writes and write merging.
// Optional write-first read bypass when RFILE_MP_BYPASS_EN is defined.
module rfile_mp
    import rfile_mp_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned XN       = 64,
    parameter int unsigned XWDT     = $clog2(XN),
    parameter int unsigned NRD      = 3,
    parameter int unsigned NWR      = 3,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned NLANE    = calc_nlane(XLEN),
    parameter int unsigned PW       = calc_pw(XLEN)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NRD-1:0]                 rd_en,
    input  logic [NRD-1:0][XWDT-1:0]       rd_addr,
    output logic [NRD-1:0][XLEN-1:0]       rd_data,
    output logic [NRD-1:0]                 rd_valid,
    input  logic [NWR-1:0]                 wr_en,
    input  logic [NWR-1:0][XWDT-1:0]       wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]       wr_data,
    input  logic [NWR-1:0][1:0]            wr_size,
    input  logic [NWR-1:0][PW-1:0]         wr_pos,
    output logic                           wr_conflict
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [XLEN-1:0]              regs      [XN];
    logic [XLEN-1:0]              next_vals [XN];
    logic [NLANE-1:0]             lane_we   [XN];
    logic [XN-1:0]                overlap;
    logic [NWR-1:0][NLANE-1:0]    wmask;
    logic [NWR-1:0][XLEN-1:0]     wdata_al;
    logic [NRD-1:0][XLEN-1:0]     rd_val;

    // Align each port's right-justified data onto its first lane.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wmask[j]    = NLANE'(lane_mask(wsize_e'(wr_size[j]), 32'(wr_pos[j]), NLANE));
            wdata_al[j] = wr_data[j] << (8 * lane_first(wsize_e'(wr_size[j]), 32'(wr_pos[j]), NLANE));
        end
    end

    generate
        for (genvar gi = 0; gi < XN; gi++) begin : g_reg
            localparam bit LOCKED = ZR && (gi == 0);
            logic [NWR-1:0] hit;

            always_comb begin
                for (int j = 0; j < NWR; j++) begin
                    hit[j] = wr_en[j] && (wr_addr[j] == XWDT'(gi)) && !LOCKED;
                end
            end

            rfile_mp_merge #(
                .XLEN  (XLEN),
                .NWR   (NWR),
                .NLANE (NLANE)
            ) u_merge (
                .cur     (regs[gi]),
                .hit     (hit),
                .mask    (wmask),
                .data    (wdata_al),
                .next    (next_vals[gi]),
                .lane_we (lane_we[gi]),
                .overlap (overlap[gi])
            );
        end
    endgenerate

    // Out-of-range addresses match no merge slot, so they read 0 and drop writes.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_val[i] = '0;
            if (32'(rd_addr[i]) < XN && !(ZR && rd_addr[i] == '0)) begin
`ifdef RFILE_MP_BYPASS_EN
                rd_val[i] = next_vals[rd_addr[i]];
`else
                rd_val[i] = regs[rd_addr[i]];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < XN; a++) regs[a] <= '0;
            rd_data     <= '0;
            rd_valid    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int a = 0; a < XN; a++) begin
                for (int l = 0; l < NLANE; l++) begin
                    if (lane_we[a][l]) regs[a][l*8 +: 8] <= next_vals[a][l*8 +: 8];
                end
            end
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i]) rd_data[i] <= rd_val[i];
            end
            rd_valid    <= rd_en;
            wr_conflict <= |overlap;
        end
    end

endmodule
